// File: rtl/tisc_pkg.sv
// Shared TISC definitions: bus widths, LSU op encodings, LSU state encodings
// and the latched request payload.
package tisc_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned RD_W   = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ST_W   = 2;

    // Memory op encodings presented by execute
    localparam logic [OP_W-1:0] OP_LOAD  = 2'b00;
    localparam logic [OP_W-1:0] OP_STORE = 2'b01;
    localparam logic [OP_W-1:0] OP_ADD   = 2'b10;
    localparam logic [OP_W-1:0] OP_SWAP  = 2'b11;

    // LSU sequencer states
    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_ACCESS = 2'd1;
    localparam logic [ST_W-1:0] ST_WRITE  = 2'd2;
    localparam logic [ST_W-1:0] ST_RESP   = 2'd3;

    // Request as captured at acceptance
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [RD_W-1:0]   rd;
    } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// Execute/writeback handshake plus the datamem port bundle seen by the LSU.
interface lsu_if;
    import tisc_pkg::*;

    // Request from execute
    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [RD_W-1:0]   req_rd;

    // Completion to writeback
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [RD_W-1:0]   resp_rd;
    logic              resp_we;
    logic              resp_carry;

    // datamem ports
    logic              mem_en;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    // LSU side
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rd,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_rd, resp_we, resp_carry,
        output mem_en, mem_waddr, mem_wdata, mem_raddr
    );

    // Execute/writeback/datamem side
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rd,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_we, resp_carry,
        input  mem_en, mem_waddr, mem_wdata, mem_raddr
    );

endinterface

// File: rtl/lsu.sv
// TISC load/store unit: one request at a time, sequences LOAD/STORE and the
// read-modify-write ops ADD and SWAP against datamem, returns a completion.
// All outputs come straight from registers; the next value of every register
// is computed in one combinational block.
module lsu
    import tisc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    lsu_if.slave bus
);

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_state;
    lsu_req_t          r_req;
    lsu_req_t          w_req;
    logic [DATA_W-1:0] r_old;
    logic [DATA_W-1:0] w_old;
    logic              r_req_ready;
    logic              w_req_ready;
    logic              r_resp_valid;
    logic              w_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic [DATA_W-1:0] w_resp_data;
    logic              r_resp_we;
    logic              w_resp_we;
    logic              r_resp_carry;
    logic              w_resp_carry;
    logic              r_mem_en;
    logic              w_mem_en;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W:0]   w_sum;

    // State and output registers; reset drops any in-flight write at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_old        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_we    <= 1'b0;
            r_resp_carry <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state;
            r_req        <= w_req;
            r_old        <= w_old;
            r_req_ready  <= w_req_ready;
            r_resp_valid <= w_resp_valid;
            r_resp_data  <= w_resp_data;
            r_resp_we    <= w_resp_we;
            r_resp_carry <= w_resp_carry;
            r_mem_en     <= w_mem_en;
            r_mem_wdata  <= w_mem_wdata;
        end
    end

    // Next-state and next-output decode; mem_en is a one-cycle pulse that is
    // only ever high while sitting in ACCESS (STORE/SWAP) or WRITE (ADD)
    always_comb begin
        w_state      = r_state;
        w_req        = r_req;
        w_old        = r_old;
        w_req_ready  = r_req_ready;
        w_resp_valid = r_resp_valid;
        w_resp_data  = r_resp_data;
        w_resp_we    = r_resp_we;
        w_resp_carry = r_resp_carry;
        w_mem_en     = 1'b0;
        w_mem_wdata  = r_mem_wdata;
        w_sum        = (DATA_W+1)'(bus.mem_rdata) + (DATA_W+1)'(r_req.wdata);

        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_state       = ST_ACCESS;
                    w_req.op      = bus.req_op;
                    w_req.addr    = bus.req_addr;
                    w_req.wdata   = bus.req_wdata;
                    w_req.rd      = bus.req_rd;
                    w_req_ready   = 1'b0;
                    w_mem_wdata   = bus.req_wdata;
                    w_mem_en      = (bus.req_op == OP_STORE) || (bus.req_op == OP_SWAP);
                    w_resp_data   = '0;
                    w_resp_we     = 1'b0;
                    w_resp_carry  = 1'b0;
                end
            end

            ST_ACCESS: begin
                // Read sees pre-write contents: a SWAP write commits at this closing edge
                w_old = bus.mem_rdata;
                case (r_req.op)
                    OP_ADD: begin
                        w_state      = ST_WRITE;
                        w_mem_en     = 1'b1;
                        w_mem_wdata  = w_sum[DATA_W-1:0];
                        w_resp_carry = w_sum[DATA_W];
                    end
                    OP_STORE: begin
                        w_state      = ST_RESP;
                        w_resp_valid = 1'b1;
                        w_resp_data  = '0;
                        w_resp_we    = 1'b0;
                    end
                    default: begin
                        w_state      = ST_RESP;
                        w_resp_valid = 1'b1;
                        w_resp_data  = bus.mem_rdata;
                        w_resp_we    = 1'b1;
                    end
                endcase
            end

            ST_WRITE: begin
                w_state      = ST_RESP;
                w_resp_valid = 1'b1;
                w_resp_data  = r_old;
                w_resp_we    = 1'b1;
            end

            ST_RESP: begin
                if (bus.resp_ready) begin
                    w_state      = ST_IDLE;
                    w_resp_valid = 1'b0;
                    w_req_ready  = 1'b1;
                end
            end

            default: begin
                w_state      = ST_IDLE;
                w_resp_valid = 1'b0;
                w_req_ready  = 1'b1;
            end
        endcase
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_rd    = r_req.rd;
    assign bus.resp_we    = r_resp_we;
    assign bus.resp_carry = r_resp_carry;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_waddr  = r_req.addr;
    assign bus.mem_raddr  = r_req.addr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule
